// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR impulse-response bank controller
// and the FIR filter wrappers that size their weight ports from it.
package fir_ctrl_pkg;

    localparam int FXP_SIZE_DEF    = 16;
    localparam int WINDOW_SIZE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } ir_state_t;

    // Tap counter width; kept at least one bit so a 2-tap window still has a counter.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ir_bank_regfile.sv
// Two-bank IR coefficient storage: writes go to the shadow bank, o_ir shows the active one.
// Optional registered readback of the active bank when FIR_IR_READBACK_EN is defined.
module ir_bank_regfile
    import fir_ctrl_pkg::*;
#(
    parameter int FXP_SIZE    = FXP_SIZE_DEF,
    parameter int WINDOW_SIZE = WINDOW_SIZE_DEF,
    parameter int CNT_W       = cnt_width(WINDOW_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [CNT_W-1:0]                wr_idx,
    input  logic [FXP_SIZE-1:0]             wr_data,
    input  logic                            swap,
    output logic                            bank_sel,
    output logic [WINDOW_SIZE*FXP_SIZE-1:0] ir
`ifdef FIR_IR_READBACK_EN
    ,
    input  logic [CNT_W-1:0]                rd_idx,
    output logic [FXP_SIZE-1:0]             rd_data
`endif
);

    logic [WINDOW_SIZE-1:0][FXP_SIZE-1:0] bank0;
    logic [WINDOW_SIZE-1:0][FXP_SIZE-1:0] bank1;
    logic [WINDOW_SIZE-1:0][FXP_SIZE-1:0] active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank0    <= '0;
            bank1    <= '0;
            bank_sel <= 1'b0;
        end else begin
            // The shadow bank is always the one not selected.
            if (wr_en) begin
                if (bank_sel) bank0[wr_idx] <= wr_data;
                else          bank1[wr_idx] <= wr_data;
            end
            if (swap) bank_sel <= ~bank_sel;
        end
    end

    assign active = bank_sel ? bank1 : bank0;
    assign ir     = active;

`ifdef FIR_IR_READBACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (int'(rd_idx) < WINDOW_SIZE) begin
            rd_data <= active[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end
`endif

endmodule

// File: rtl/fir_ir_bank_controller.sv
// Serial IR loader with atomic shadow/active bank swap on a sample boundary.
// Define FIR_IR_READBACK_EN to add the rd_idx/rd_data readback port.
module fir_ir_bank_controller
    import fir_ctrl_pkg::*;
#(
    parameter int FXP_SIZE    = FXP_SIZE_DEF,
    parameter int WINDOW_SIZE = WINDOW_SIZE_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic                            cfg_valid,
    input  logic [FXP_SIZE-1:0]             cfg_data,
    output logic                            cfg_ready,
    input  logic                            cfg_abort,
    input  logic                            sample_valid,
    output logic [WINDOW_SIZE*FXP_SIZE-1:0] o_ir,
    output logic                            o_bank_sel,
    output logic                            o_busy,
    output logic                            o_swap_done,
    output logic                            o_error,
    output ir_state_t                       o_state
`ifdef FIR_IR_READBACK_EN
    ,
    input  logic [cnt_width(WINDOW_SIZE)-1:0] rd_idx,
    output logic [FXP_SIZE-1:0]               rd_data
`endif
);

    localparam int               CNT_W    = cnt_width(WINDOW_SIZE);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(WINDOW_SIZE - 1);

    // Handshake: a coefficient is taken on any cycle where cfg_valid && cfg_ready;
    // cfg_ready is a registered function of state and never depends on cfg_valid.
    ir_state_t        state;
    logic [CNT_W-1:0] tap_cnt;
    logic             wr_en;
    logic             swap;

    assign wr_en = (state == LOAD) && cfg_valid && !cfg_abort && !cfg_start;
    assign swap  = (state == ARMED) && sample_valid && !cfg_abort && !cfg_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tap_cnt     <= '0;
            cfg_ready   <= 1'b0;
            o_busy      <= 1'b0;
            o_swap_done <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_swap_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with an abort is dropped.
                    if (cfg_start && !cfg_abort) begin
                        tap_cnt   <= '0;
                        o_error   <= 1'b0;
                        state     <= LOAD;
                        cfg_ready <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                LOAD, ARMED: begin
                    if (cfg_abort) begin
                        tap_cnt   <= '0;
                        state     <= IDLE;
                        cfg_ready <= 1'b0;
                        o_busy    <= 1'b0;
                    end else if (cfg_start) begin
                        tap_cnt   <= '0;
                        o_error   <= 1'b1;
                        state     <= LOAD;
                        cfg_ready <= 1'b1;
                        o_busy    <= 1'b1;
                    end else if (wr_en) begin
                        if (tap_cnt == LAST_TAP) begin
                            tap_cnt   <= '0;
                            state     <= ARMED;
                            cfg_ready <= 1'b0;
                        end else begin
                            tap_cnt <= tap_cnt + 1'b1;
                        end
                    end else if (swap) begin
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_swap_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state;

    ir_bank_regfile #(
        .FXP_SIZE    (FXP_SIZE),
        .WINDOW_SIZE (WINDOW_SIZE),
        .CNT_W       (CNT_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (tap_cnt),
        .wr_data  (cfg_data),
        .swap     (swap),
        .bank_sel (o_bank_sel),
        .ir       (o_ir)
`ifdef FIR_IR_READBACK_EN
        ,
        .rd_idx   (rd_idx),
        .rd_data  (rd_data)
`endif
    );

endmodule

// File: tb/tb_fir_ir_bank_controller.sv
// Directed bench for fir_ir_bank_controller; readback checks are built when
// FIR_IR_READBACK_EN is defined.
module tb_fir_ir_bank_controller;
    import fir_ctrl_pkg::*;

    localparam int FXP = 16;
    localparam int WIN = 16;

    logic                 clk;
    logic                 rst;
    logic                 cfg_start;
    logic                 cfg_valid;
    logic [FXP-1:0]       cfg_data;
    logic                 cfg_ready;
    logic                 cfg_abort;
    logic                 sample_valid;
    logic [WIN*FXP-1:0]   o_ir;
    logic                 o_bank_sel;
    logic                 o_busy;
    logic                 o_swap_done;
    logic                 o_error;
    ir_state_t            o_state;
`ifdef FIR_IR_READBACK_EN
    logic [3:0]           rd_idx;
    logic [FXP-1:0]       rd_data;
`endif

    fir_ir_bank_controller #(.FXP_SIZE(FXP), .WINDOW_SIZE(WIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .cfg_abort    (cfg_abort),
        .sample_valid (sample_valid),
        .o_ir         (o_ir),
        .o_bank_sel   (o_bank_sel),
        .o_busy       (o_busy),
        .o_swap_done  (o_swap_done),
        .o_error      (o_error),
        .o_state      (o_state)
`ifdef FIR_IR_READBACK_EN
        ,
        .rd_idx       (rd_idx),
        .rd_data      (rd_data)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [FXP-1:0] exp_q[$];
    logic [FXP-1:0] exp_ir [WIN];
    logic           exp_sel;
    int             n_total;
    int             n_bad;
    int             ready_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag);
        for (int i = 0; i < WIN; i++)
            check($sformatf("%s_ir%0d", tag, i), 32'(o_ir[i*FXP +: FXP]), 32'(exp_ir[i]));
    endtask

    // driver tasks
    task automatic start_load();
        exp_q.delete();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_taps(input logic [FXP-1:0] base, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = base + FXP'(i);
            exp_q.push_back(base + FXP'(i));
            if (cfg_ready) ready_cycles++;
            tick();
            if (gaps) begin
                cfg_valid = 1'b0;
                cfg_data  = 16'hBEEF;
                tick();
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic swap_and_check(input string tag);
        for (int i = 0; i < 3; i++) tick();
        check({tag, "_armed_state"}, 32'(o_state), 32'(ARMED));
        check({tag, "_armed_sel"}, 32'(o_bank_sel), 32'(exp_sel));
        check({tag, "_armed_busy"}, 32'(o_busy), 32'd1);
        check({tag, "_armed_nopulse"}, 32'(o_swap_done), 32'd0);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        exp_sel = ~exp_sel;
        for (int i = 0; i < WIN; i++) exp_ir[i] = exp_q.pop_front();
        check({tag, "_swap_pulse"}, 32'(o_swap_done), 32'd1);
        check({tag, "_swap_sel"}, 32'(o_bank_sel), 32'(exp_sel));
        check({tag, "_swap_state"}, 32'(o_state), 32'(IDLE));
        check({tag, "_swap_busy"}, 32'(o_busy), 32'd0);
        check_ir(tag);
        tick();
        check({tag, "_pulse_once"}, 32'(o_swap_done), 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        exp_sel = 1'b0;
        for (int i = 0; i < WIN; i++) exp_ir[i] = '0;
        rst = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        cfg_abort = 1'b0;
        sample_valid = 1'b0;
`ifdef FIR_IR_READBACK_EN
        rd_idx = '0;
`endif
        tick();
        tick();
        rst = 1'b1;
        tick();

        // reset state
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_sel", 32'(o_bank_sel), 32'd0);
        check("rst_err", 32'(o_error), 32'd0);
        check("rst_pulse", 32'(o_swap_done), 32'd0);
        check("rst_state", 32'(o_state), 32'(IDLE));
        check_ir("rst");
`ifdef FIR_IR_READBACK_EN
        check("rst_rd", 32'(rd_data), 32'd0);
`endif

        // full load, cfg_valid held high
        start_load();
        ready_cycles = 0;
        send_taps(16'h0100, WIN, 1'b0);
        check("full_ready_cycles", 32'(ready_cycles), 32'd16);
        check("full_ready_drop", 32'(cfg_ready), 32'd0);
        check("full_sel_noswap", 32'(o_bank_sel), 32'd0);
        swap_and_check("full");

`ifdef FIR_IR_READBACK_EN
        rd_idx = 4'd3;
        tick();
        check("rd_idx3", 32'(rd_data), 32'h0103);
        rd_idx = 4'd15;
        tick();
        check("rd_idx15", 32'(rd_data), 32'h010F);
`endif

        // cfg_valid while idle: ignored
        cfg_valid = 1'b1;
        cfg_data = 16'hDEAD;
        tick();
        tick();
        cfg_valid = 1'b0;
        check("idle_valid_ready", 32'(cfg_ready), 32'd0);
        check("idle_valid_err", 32'(o_error), 32'd0);
        check("idle_valid_state", 32'(o_state), 32'(IDLE));
        check_ir("idle_valid");

        // gapped load
        start_load();
        send_taps(16'h0200, WIN, 1'b1);
        swap_and_check("gap");

        // abort in LOAD after 8 taps
        start_load();
        send_taps(16'h0300, 8, 1'b0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        exp_q.delete();
        check("abort_load_state", 32'(o_state), 32'(IDLE));
        check("abort_load_busy", 32'(o_busy), 32'd0);
        check("abort_load_ready", 32'(cfg_ready), 32'd0);
        check("abort_load_sel", 32'(o_bank_sel), 32'(exp_sel));
        check_ir("abort_load");

        // abort in ARMED together with sample_valid
        start_load();
        send_taps(16'h0400, WIN, 1'b0);
        check("abort_arm_pre", 32'(o_state), 32'(ARMED));
        cfg_abort = 1'b1;
        sample_valid = 1'b1;
        tick();
        cfg_abort = 1'b0;
        exp_q.delete();
        check("abort_arm_pulse", 32'(o_swap_done), 32'd0);
        check("abort_arm_sel", 32'(o_bank_sel), 32'(exp_sel));
        check("abort_arm_state", 32'(o_state), 32'(IDLE));
        tick();
        sample_valid = 1'b0;
        check("abort_arm_idle_sv", 32'(o_bank_sel), 32'(exp_sel));
        check_ir("abort_arm");

        // restart during LOAD at tap 7
        start_load();
        send_taps(16'h0500, 7, 1'b0);
        exp_q.delete();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("restart_err", 32'(o_error), 32'd1);
        check("restart_state", 32'(o_state), 32'(LOAD));
        check("restart_ready", 32'(cfg_ready), 32'd1);
        send_taps(16'h0600, WIN, 1'b0);
        swap_and_check("restart");
        check("restart_err_sticky", 32'(o_error), 32'd1);
        start_load();
        check("restart_err_clear", 32'(o_error), 32'd0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;

        // reset mid-load after 5 taps
        start_load();
        send_taps(16'h0700, 5, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < WIN; i++) exp_ir[i] = '0;
        check_ir("midrst");
        check("midrst_sel", 32'(o_bank_sel), 32'd0);
        check("midrst_ready", 32'(cfg_ready), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_err", 32'(o_error), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_state", 32'(o_state), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
